segment_remover_rr_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares one segment remover datapath between NUM_SOURCES AXI-Stream requesters.

---
 rtl/nmu_axis_pkg.sv | 10 +
 rtl/rr_next_index.sv | 34 +++
 rtl/segment_remover_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_segment_remover_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmu_axis_pkg.sv
// Shared AXI-Stream arbitration types.
//   arb_state_t : packet arbiter state (IDLE = arbitrating, BUSY = packet in flight)
package nmu_axis_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_next_index.sv
// Round-robin search: finds the first set bit of req starting just above
// `last` and wrapping around.  Purely combinational.
//   req   in  N            request vector
//   last  in  $clog2(N)    index granted most recently
//   idx   out $clog2(N)    next index to grant (valid when found)
//   found out 1            at least one request bit is set
module rr_next_index #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          found
);

   int unsigned w_cand;

   // Offsets 1..N visit every index once, ending on `last` itself, so a
   // lone requester that was just served is still re-granted.
   always_comb begin
      idx    = '0;
      found  = 1'b0;
      w_cand = 0;
      for (int unsigned off = 1; off <= N; off++) begin
         w_cand = (32'(last) + off) % N;
         if (!found && req[IW'(w_cand)]) begin
            found = 1'b1;
            idx   = IW'(w_cand);
         end
      end
   end

endmodule

// File: rtl/segment_remover_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one segment remover input
// between NUM_SOURCES AXI-Stream requesters.  One source is granted per
// packet; the grant is held until that source's tlast handshake.  Each
// output beat carries the source ID in the upper tuser bits.
//   aclk, aresetn       clock, asynchronous active-low reset
//   src_enable          per-source eligibility for new grants
//   axis_in_*           packed per-source AXI-Stream inputs (source i at slice i)
//   axis_out_*          muxed stream to the remover, tuser = {src_id, src tuser}
//   cur_grant           granted source index
//   busy                high while a packet is in flight
module segment_remover_rr_arbiter
   import nmu_axis_pkg::*;
#(
   parameter  int AXIS_BUS_WIDTH   = 64,
   parameter  int AXIS_TUSER_WIDTH = 4,
   parameter  int NUM_SOURCES      = 4,
   localparam int SRC_ID_BITS      = $clog2(NUM_SOURCES),
   localparam int NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8
) (
   input  logic                                      aclk,
   input  logic                                      aresetn,
   input  logic [NUM_SOURCES-1:0]                    src_enable,
   input  logic [NUM_SOURCES*AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
   input  logic [NUM_SOURCES*NUM_BUS_BYTES-1:0]      axis_in_tkeep,
   input  logic [NUM_SOURCES*AXIS_TUSER_WIDTH-1:0]   axis_in_tuser,
   input  logic [NUM_SOURCES-1:0]                    axis_in_tlast,
   input  logic [NUM_SOURCES-1:0]                    axis_in_tvalid,
   output logic [NUM_SOURCES-1:0]                    axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]                 axis_out_tdata,
   output logic [NUM_BUS_BYTES-1:0]                  axis_out_tkeep,
   output logic [AXIS_TUSER_WIDTH+SRC_ID_BITS-1:0]   axis_out_tuser,
   output logic                                      axis_out_tlast,
   output logic                                      axis_out_tvalid,
   input  logic                                      axis_out_tready,
   output logic [SRC_ID_BITS-1:0]                    cur_grant,
   output logic                                      busy
);

   arb_state_t             r_state;
   arb_state_t             w_state_nxt;
   logic [SRC_ID_BITS-1:0] r_grant;
   logic [SRC_ID_BITS-1:0] r_last_grant;

   logic [NUM_SOURCES-1:0] w_req;
   logic [SRC_ID_BITS-1:0] w_arb_idx;
   logic                   w_arb_found;
   logic                   w_pkt_done;

   logic [AXIS_BUS_WIDTH-1:0]   w_src_tdata [NUM_SOURCES];
   logic [NUM_BUS_BYTES-1:0]    w_src_tkeep [NUM_SOURCES];
   logic [AXIS_TUSER_WIDTH-1:0] w_src_tuser [NUM_SOURCES];

   assign w_req = axis_in_tvalid & src_enable;

   rr_next_index #(
      .N (NUM_SOURCES)
   ) u_rr_next_index (
      .req   (w_req),
      .last  (r_last_grant),
      .idx   (w_arb_idx),
      .found (w_arb_found)
   );

   // Unpack the flat per-source buses so the output mux can index them.
   always_comb begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
         w_src_tdata[i] = axis_in_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
         w_src_tkeep[i] = axis_in_tkeep[i*NUM_BUS_BYTES +: NUM_BUS_BYTES];
         w_src_tuser[i] = axis_in_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
      end
   end

   assign w_pkt_done = axis_out_tvalid & axis_out_tready & axis_out_tlast;

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant registers: only updated while arbitrating, so src_enable
   // changes mid-packet cannot revoke the current grant.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_grant      <= '0;
         r_last_grant <= SRC_ID_BITS'(NUM_SOURCES - 1);
      end else if (r_state == IDLE && w_arb_found) begin
         r_grant      <= w_arb_idx;
         r_last_grant <= w_arb_idx;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (w_arb_found) w_state_nxt = BUSY;
         BUSY: if (w_pkt_done)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: zero-latency pass-through of the granted source while
   // BUSY; everything quiet while arbitrating.
   always_comb begin
      axis_in_tready  = '0;
      axis_out_tdata  = '0;
      axis_out_tkeep  = '0;
      axis_out_tuser  = '0;
      axis_out_tlast  = 1'b0;
      axis_out_tvalid = 1'b0;
      if (r_state == BUSY) begin
         axis_out_tdata           = w_src_tdata[r_grant];
         axis_out_tkeep           = w_src_tkeep[r_grant];
         axis_out_tuser           = {r_grant, w_src_tuser[r_grant]};
         axis_out_tlast           = axis_in_tlast[r_grant];
         axis_out_tvalid          = axis_in_tvalid[r_grant];
         axis_in_tready[r_grant]  = axis_out_tready;
      end
   end

   assign busy      = (r_state == BUSY);
   assign cur_grant = r_grant;

endmodule

// File: tb/tb_segment_remover_rr_arbiter.sv
// Directed bench for segment_remover_rr_arbiter: behavioural AXI-Stream
// sources, an output beat log, and hand-computed expected sequences.
module tb_segment_remover_rr_arbiter;

   localparam int W   = 64;
   localparam int TU  = 4;
   localparam int NS  = 4;
   localparam int KB  = W / 8;
   localparam int IDB = 2;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [NS-1:0]     src_enable;
   logic [NS*W-1:0]   axis_in_tdata;
   logic [NS*KB-1:0]  axis_in_tkeep;
   logic [NS*TU-1:0]  axis_in_tuser;
   logic [NS-1:0]     axis_in_tlast;
   logic [NS-1:0]     axis_in_tvalid;
   logic [NS-1:0]     axis_in_tready;
   logic [W-1:0]      axis_out_tdata;
   logic [KB-1:0]     axis_out_tkeep;
   logic [TU+IDB-1:0] axis_out_tuser;
   logic              axis_out_tlast;
   logic              axis_out_tvalid;
   logic              axis_out_tready;
   logic [IDB-1:0]    cur_grant;
   logic              busy;

   always #5 aclk = ~aclk;

   segment_remover_rr_arbiter #(
      .AXIS_BUS_WIDTH   (W),
      .AXIS_TUSER_WIDTH (TU),
      .NUM_SOURCES      (NS)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .src_enable      (src_enable),
      .axis_in_tdata   (axis_in_tdata),
      .axis_in_tkeep   (axis_in_tkeep),
      .axis_in_tuser   (axis_in_tuser),
      .axis_in_tlast   (axis_in_tlast),
      .axis_in_tvalid  (axis_in_tvalid),
      .axis_in_tready  (axis_in_tready),
      .axis_out_tdata  (axis_out_tdata),
      .axis_out_tkeep  (axis_out_tkeep),
      .axis_out_tuser  (axis_out_tuser),
      .axis_out_tlast  (axis_out_tlast),
      .axis_out_tvalid (axis_out_tvalid),
      .axis_out_tready (axis_out_tready),
      .cur_grant       (cur_grant),
      .busy            (busy)
   );

   int errors   = 0;
   int checks   = 0;
   int cyc      = 0;
   int rdy_viol = 0;

   // Behavioural source state
   int s_pkts [NS];
   int s_len  [NS];
   int s_beat [NS];
   int s_pkt  [NS];
   bit s_hold [NS];
   bit ordy_toggle;
   bit clr_en1_hook;

   // Accepted output beats
   logic [W-1:0]      log_data [$];
   logic [TU+IDB-1:0] log_user [$];
   logic              log_last [$];
   logic [KB-1:0]     log_keep [$];
   int                log_cyc  [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] beat_word(input int s, input int p, input int b);
      return {40'h0, 8'(s), 8'(p), 8'(b)};
   endfunction

   task automatic setup_src(input int i, input int pkts, input int len);
      s_pkts[i] = pkts;
      s_len[i]  = len;
      s_beat[i] = 0;
      s_pkt[i]  = 0;
      s_hold[i] = 1'b0;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_user.delete();
      log_last.delete();
      log_keep.delete();
      log_cyc.delete();
      rdy_viol = 0;
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NS; i++) begin
         axis_in_tvalid[i]        = (s_pkts[i] > 0) && !s_hold[i];
         axis_in_tdata[i*W +: W]  = beat_word(i, s_pkt[i], s_beat[i]);
         axis_in_tlast[i]         = (s_beat[i] == s_len[i] - 1);
         axis_in_tkeep[i*KB +: KB] = axis_in_tlast[i] ? 8'h0F : 8'hFF;
         axis_in_tuser[i*TU +: TU] = 4'(i + 5);
      end
      axis_out_tready = ordy_toggle ? (cyc % 2 == 0) : 1'b1;
   endtask

   // One clock: drive at negedge, sample 2 ns later, then advance sources
   // that handshook and wait for the next negedge.
   task automatic tick();
      apply_inputs();
      #2;
      if (($countones(axis_in_tready) > 1) || ((axis_in_tready != '0) && !axis_out_tready))
         rdy_viol++;
      if (axis_out_tvalid && axis_out_tready) begin
         log_data.push_back(axis_out_tdata);
         log_user.push_back(axis_out_tuser);
         log_last.push_back(axis_out_tlast);
         log_keep.push_back(axis_out_tkeep);
         log_cyc.push_back(cyc);
         if (clr_en1_hook && axis_out_tuser[5:4] == 2'd1) src_enable[1] = 1'b0;
      end
      for (int i = 0; i < NS; i++) begin
         if (axis_in_tvalid[i] && axis_in_tready[i]) begin
            if (s_beat[i] == s_len[i] - 1) begin
               s_beat[i] = 0;
               s_pkt[i]++;
               s_pkts[i]--;
            end else begin
               s_beat[i]++;
            end
         end
      end
      @(posedge aclk);
      @(negedge aclk);
      cyc++;
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (log_data.size() < n && k < budget) begin
         tick();
         k++;
      end
      check_eq({tag, "_beats"}, log_data.size(), n);
   endtask

   initial begin
      int c0;
      int ord4 [3];
      ord4 = '{3, 0, 1};

      aresetn      = 1'b0;
      src_enable   = '1;
      ordy_toggle  = 1'b0;
      clr_en1_hook = 1'b0;
      for (int i = 0; i < NS; i++) setup_src(i, 1, 3);

      // Reset held with every source requesting
      @(negedge aclk);
      apply_inputs();
      #2;
      check_eq("rst_tready", axis_in_tready, 0);
      check_eq("rst_tvalid", axis_out_tvalid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_grant", cur_grant, 0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;

      // Four simultaneous 3-beat packets
      clear_log();
      run_until(12, 40, "t2");
      for (int k = 0; k < 12 && k < log_data.size(); k++) begin
         check_eq("t2_data", log_data[k], beat_word(k / 3, 0, k % 3));
         check_eq("t2_user", log_user[k], {2'(k / 3), 4'(k / 3 + 5)});
         check_eq("t2_last", log_last[k], (k % 3 == 2));
      end
      if (log_data.size() == 12) begin
         check_eq("t2_keep_first", log_keep[0], 8'hFF);
         check_eq("t2_keep_last", log_keep[11], 8'h0F);
         check_eq("t2_span", log_cyc[11] - log_cyc[0] + 1, 15);
         check_eq("t2_bubble", log_cyc[3] - log_cyc[2], 2);
      end
      check_eq("t2_rdy", rdy_viol, 0);

      // Backpressure on a 4-beat packet from source 1
      clear_log();
      ordy_toggle = 1'b1;
      setup_src(1, 1, 4);
      run_until(4, 40, "t3");
      repeat (3) tick();
      check_eq("t3_no_dup", log_data.size(), 4);
      for (int k = 0; k < 4 && k < log_data.size(); k++)
         check_eq("t3_data", log_data[k], beat_word(1, 0, k));
      if (log_data.size() == 4) check_eq("t3_span", log_cyc[3] - log_cyc[0], 6);
      check_eq("t3_rdy", rdy_viol, 0);
      ordy_toggle = 1'b0;

      // Enable mask: src 2 fenced off, src 1 disabled mid-packet
      clear_log();
      src_enable = 4'b1011;
      for (int i = 0; i < NS; i++) setup_src(i, 1, 3);
      clr_en1_hook = 1'b1;
      run_until(9, 60, "t4");
      repeat (6) tick();
      check_eq("t4_no_src2", log_data.size(), 9);
      check_eq("t4_idle", busy, 0);
      for (int k = 0; k < 9 && k < log_data.size(); k++)
         check_eq("t4_data", log_data[k], beat_word(ord4[k / 3], 0, k % 3));
      check_eq("t4_rdy", rdy_viol, 0);
      clr_en1_hook = 1'b0;
      s_pkts[2]    = 0;
      src_enable   = '1;

      // Fairness between two continuous 1-beat streams, fresh from reset
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      clear_log();
      setup_src(0, 20, 1);
      setup_src(3, 20, 1);
      run_until(20, 80, "t5");
      for (int k = 0; k < 20 && k < log_data.size(); k++)
         check_eq("t5_grant", log_user[k][5:4], (k % 2 == 1) ? 3 : 0);
      if (log_data.size() == 20) check_eq("t5_span", log_cyc[19] - log_cyc[0], 38);
      s_pkts[0] = 0;
      s_pkts[3] = 0;

      // Reset during beat 2 of a 5-beat packet
      clear_log();
      setup_src(0, 1, 5);
      run_until(2, 20, "t6_pre");
      apply_inputs();
      #2;
      check_eq("t6_beat2_valid", axis_out_tvalid, 1);
      check_eq("t6_beat2_data", axis_out_tdata, beat_word(0, 0, 2));
      aresetn = 1'b0;
      #1;
      check_eq("t6_rst_tready", axis_in_tready, 0);
      check_eq("t6_rst_tvalid", axis_out_tvalid, 0);
      check_eq("t6_rst_busy", busy, 0);
      check_eq("t6_rst_grant", cur_grant, 0);
      @(negedge aclk);
      @(negedge aclk);
      setup_src(0, 1, 5);
      aresetn = 1'b1;
      clear_log();
      c0 = cyc;
      run_until(5, 30, "t6");
      for (int k = 0; k < 5 && k < log_data.size(); k++) begin
         check_eq("t6_data", log_data[k], beat_word(0, 0, k));
         check_eq("t6_user", log_user[k], {2'd0, 4'd5});
      end
      if (log_data.size() == 5) check_eq("t6_rearb", log_cyc[0] - c0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
